// File: rtl/fifo_wr_burst_arbiter_if.sv
// Source/FIFO write-side bundle for the burst arbiter.
// Arbiter takes the slave view, the source/FIFO side takes the master view.
interface fifo_wr_burst_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 11
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*LEN_W-1:0]  req_len_i;
  logic [NUM_REQ*DATA_W-1:0] src_data_i;
  logic [NUM_REQ-1:0]        src_vld_i;
  logic [NUM_REQ-1:0]        src_rdy_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic [NUM_REQ-1:0]        burst_done_o;
  logic                      fifo_wr_en_o;
  logic [DATA_W-1:0]         fifo_wr_data_o;
  logic                      fifo_wr_vld_i;
  logic                      busy_o;

  modport slave (
    input  req_i, req_len_i, src_data_i,
    input  src_vld_i, fifo_wr_vld_i,
    output src_rdy_o, grant_o, burst_done_o,
    output fifo_wr_en_o, fifo_wr_data_o, busy_o
  );

  modport master (
    output req_i, req_len_i, src_data_i,
    output src_vld_i, fifo_wr_vld_i,
    input  src_rdy_o, grant_o, burst_done_o,
    input  fifo_wr_en_o, fifo_wr_data_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_burst_arbiter.sv
// Round-robin burst arbiter for the prefetch FIFO write port.
// A granted source owns the port until len+1 bytes have moved.
module fifo_wr_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 11
) (
  input  logic clk,
  input  logic rst,
  fifo_wr_burst_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic               xfer;

  // first requester after the last winner, with wrap
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld &&
          bus.req_i[(int'(rr_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  assign xfer = (state_q == XFER) &&
                bus.src_vld_i[gidx_q] &&
                bus.fifo_wr_vld_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = XFER;
          grant_d = NUM_REQ'(1) << win_idx;
          gidx_d  = win_idx;
          rr_d    = win_idx;
          cnt_d   = bus.req_len_i[int'(win_idx)*LEN_W +: LEN_W];
        end
      end
      XFER: begin
        if (xfer) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            grant_d = '0;
            done_d  = grant_q;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rr_q    <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant_o      = grant_q;
  assign bus.burst_done_o = done_q;
  assign bus.busy_o       = (state_q == XFER);
  assign bus.src_rdy_o    = grant_q &
                            {NUM_REQ{bus.fifo_wr_vld_i}};
  assign bus.fifo_wr_en_o = xfer;
  assign bus.fifo_wr_data_o =
    (|grant_q) ?
    bus.src_data_i[int'(gidx_q)*DATA_W +: DATA_W] : '0;
endmodule
